// File: rtl/grid_game_ctrl.sv
// N x N, K-in-a-row two-player game controller: cursor, placement FSM and incremental win/draw check.
// Optional feature: define GRID_CURSOR_WRAP_EN to make cursor moves wrap at the board edges instead of saturating.
module grid_game_ctrl #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2:0]           dir,
  input  logic                 confirm,
  output logic [$clog2(N)-1:0] cur_row,
  output logic [$clog2(N)-1:0] cur_col,
  output logic [2*N*N-1:0]     board,
  output logic [1:0]           turn,
  output logic                 busy,
  output logic                 illegal,
  output logic [1:0]           winner,
  output logic                 game_over
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N*N+1);
  localparam logic [RW-1:0] LAST = RW'(N-1);
`ifdef GRID_CURSOR_WRAP_EN
  localparam logic [RW-1:0] PAST_LOW  = LAST;
  localparam logic [RW-1:0] PAST_HIGH = '0;
`else
  localparam logic [RW-1:0] PAST_LOW  = '0;
  localparam logic [RW-1:0] PAST_HIGH = LAST;
`endif

  typedef enum logic [2:0] {IDLE, PLACE, CHECK, SWITCH, DONE} state_t;
  state_t state;

  logic [2:0]    dir_q;
  logic          confirm_q;
  logic [CW-1:0] placed;
  logic [1:0]    axis;
  logic          sense;
  int            p_row, p_col, w_row, w_col, steps, run;
  logic [RW-1:0] nxt_row, nxt_col;
  logic [1:0]    cursor_cell;
  int            dr, dc, nr, nc;
  logic          step_ok;

  function automatic logic is_move(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

  always_comb begin
    nxt_row = cur_row;
    nxt_col = cur_col;
    if (is_move(dir) && !is_move(dir_q)) begin
      case (dir)
        3'd1:    nxt_row = (cur_row == '0)   ? PAST_LOW  : cur_row - RW'(1);
        3'd2:    nxt_row = (cur_row == LAST) ? PAST_HIGH : cur_row + RW'(1);
        3'd3:    nxt_col = (cur_col == LAST) ? PAST_HIGH : cur_col + RW'(1);
        3'd4:    nxt_col = (cur_col == '0)   ? PAST_LOW  : cur_col - RW'(1);
        default: ;
      endcase
    end
  end

  assign cursor_cell = board[2*(int'(cur_row)*N + int'(cur_col)) +: 2];

  // One step of the line walk: axis 0..3 = horizontal, vertical, diagonal, anti-diagonal; sense 1 walks backwards.
  always_comb begin
    dr = 0;
    dc = 1;
    case (axis)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (sense) begin
      dr = -dr;
      dc = -dc;
    end
    nr = w_row + dr;
    nc = w_col + dc;
    step_ok = 1'b0;
    if (nr >= 0 && nr < N && nc >= 0 && nc < N)
      step_ok = (board[2*(nr*N + nc) +: 2] == turn);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      dir_q     <= '0;
      confirm_q <= 1'b0;
      cur_row   <= '0;
      cur_col   <= '0;
      board     <= '0;
      turn      <= 2'd1;
      busy      <= 1'b0;
      illegal   <= 1'b0;
      winner    <= 2'd0;
      game_over <= 1'b0;
      placed    <= '0;
      axis      <= '0;
      sense     <= 1'b0;
      p_row     <= 0;
      p_col     <= 0;
      w_row     <= 0;
      w_col     <= 0;
      steps     <= 0;
      run       <= 1;
    end else begin
      dir_q     <= dir;
      confirm_q <= confirm;
      illegal   <= 1'b0;
      cur_row   <= nxt_row;
      cur_col   <= nxt_col;
      case (state)
        IDLE: begin
          if (confirm && !confirm_q) begin
            if (cursor_cell == 2'd0) begin
              p_row <= int'(cur_row);
              p_col <= int'(cur_col);
              busy  <= 1'b1;
              state <= PLACE;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        PLACE: begin
          board[2*(p_row*N + p_col) +: 2] <= turn;
          placed <= placed + CW'(1);
          w_row  <= p_row;
          w_col  <= p_col;
          axis   <= '0;
          sense  <= 1'b0;
          steps  <= 0;
          run    <= 1;
          state  <= CHECK;
        end
        CHECK: begin
          if (step_ok && run + 1 >= K) begin
            winner    <= turn;
            game_over <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            if (step_ok) begin
              w_row <= nr;
              w_col <= nc;
              steps <= steps + 1;
              run   <= run + 1;
            end
            // A sense ends on a mismatch/edge or in the same cycle as its last allowed step.
            if (!step_ok || steps + 1 == K - 1) begin
              w_row <= p_row;
              w_col <= p_col;
              steps <= 0;
              if (!sense) begin
                sense <= 1'b1;
              end else begin
                sense <= 1'b0;
                run   <= 1;
                axis  <= axis + 2'd1;
                if (axis == 2'd3) begin
                  if (placed == CW'(N*N)) begin
                    winner    <= 2'd3;
                    game_over <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                  end else begin
                    state <= SWITCH;
                  end
                end
              end
            end
          end
        end
        SWITCH: begin
          turn  <= (turn == 2'd1) ? 2'd2 : 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_game_ctrl.sv
// Self-checking bench for grid_game_ctrl: directed vector table, corner-case sequences and
// random play checked against a board-level game model (3x3/K=3 main DUT, 5x5/K=4 second DUT).
module tb_grid_game_ctrl;
  localparam int N = 3, K = 3, RW = $clog2(N);
  localparam int N5 = 5, K5 = 4, RW5 = $clog2(N5);
`ifdef GRID_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0;
  logic [2:0] dir = '0, dir5 = '0;
  logic confirm = 1'b0, confirm5 = 1'b0;
  logic [RW-1:0] cur_row, cur_col;
  logic [2*N*N-1:0] board;
  logic [1:0] turn, winner;
  logic busy, illegal, game_over;
  logic [RW5-1:0] cur_row5, cur_col5;
  logic [2*N5*N5-1:0] board5;
  logic [1:0] turn5, winner5;
  logic busy5, illegal5, game_over5;

  int tests = 0, fails = 0;
  int mb[N][N];
  int m_row, m_col, m_turn, m_win, m_cnt;
  int c5r, c5c;

  typedef struct { int d; bit c; int er; int ec; int et; int ew; int ei; } vec_t;
  vec_t tbl[15];

  grid_game_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .resetn(resetn), .dir(dir), .confirm(confirm),
    .cur_row(cur_row), .cur_col(cur_col), .board(board), .turn(turn),
    .busy(busy), .illegal(illegal), .winner(winner), .game_over(game_over));

  grid_game_ctrl #(.N(N5), .K(K5)) dut5 (
    .clk(clk), .resetn(resetn), .dir(dir5), .confirm(confirm5),
    .cur_row(cur_row5), .cur_col(cur_col5), .board(board5), .turn(turn5),
    .busy(busy5), .illegal(illegal5), .winner(winner5), .game_over(game_over5));

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic void model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mb[r][c] = 0;
    m_row = 0; m_col = 0; m_turn = 1; m_win = 0; m_cnt = 0;
  endfunction

  function automatic void model_move(int d);
    case (d)
      1: if (m_row > 0) m_row--; else m_row = WRAP ? N-1 : 0;
      2: if (m_row < N-1) m_row++; else m_row = WRAP ? 0 : N-1;
      3: if (m_col < N-1) m_col++; else m_col = WRAP ? 0 : N-1;
      4: if (m_col > 0) m_col--; else m_col = WRAP ? N-1 : 0;
      default: ;
    endcase
  endfunction

  function automatic bit has_line(int p);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int a = 0; a < 4; a++) begin
          int dr, dc, cnt;
          dr = (a == 0) ? 0 : 1;
          dc = (a == 0) ? 1 : (a == 1) ? 0 : (a == 2) ? 1 : -1;
          cnt = 0;
          for (int s = 0; s < K; s++) begin
            int rr, cc;
            rr = r + s*dr;
            cc = c + s*dc;
            if (rr >= 0 && rr < N && cc >= 0 && cc < N)
              if (mb[rr][cc] == p) cnt++;
          end
          if (cnt == K) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic void model_place();
    if (m_win != 0 || mb[m_row][m_col] != 0) return;
    mb[m_row][m_col] = m_turn;
    m_cnt++;
    if (has_line(m_turn)) m_win = m_turn;
    else if (m_cnt == N*N) m_win = 3;
    else m_turn = 3 - m_turn;
  endfunction

  function automatic logic [2*N*N-1:0] model_board();
    logic [2*N*N-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) v[2*(r*N+c) +: 2] = 2'(mb[r][c]);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("cur_row", cur_row, m_row);
    checkOutput("cur_col", cur_col, m_col);
    checkOutput("board", board, model_board());
    checkOutput("turn", turn, m_turn);
    checkOutput("winner", winner, m_win);
    checkOutput("game_over", game_over, m_win != 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  task automatic doReset();
    resetn = 1'b0; dir = '0; confirm = 1'b0; dir5 = '0; confirm5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  // One command cycle (optional move and/or confirm), then wait out any placement and check everything.
  task automatic applyStimulus(input int d, input bit c, output int got_ill, output int lat);
    bit acc;
    int exp_ill;
    acc = c && (m_win == 0) && (mb[m_row][m_col] == 0);
    exp_ill = (c && m_win == 0 && mb[m_row][m_col] != 0) ? 1 : 0;
    if (c) model_place();
    model_move(d);
    dir = 3'(d);
    confirm = c;
    @(posedge clk);
    #1;
    dir = '0;
    confirm = 1'b0;
    got_ill = int'(illegal);
    checkOutput("illegal", illegal, exp_ill);
    checkOutput("busy_rise", busy, acc);
    lat = 0;
    while (busy && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (acc) checkOutput("busy_latency_ok", lat <= 8*(K-1)+2, 1);
    @(posedge clk);
    #1;
    checkOutput("illegal_one_cycle", illegal, 0);
    checkState();
  endtask

  task automatic gotoCell(input int r, input int c);
    int ill, lat;
    while (m_row < r) applyStimulus(2, 1'b0, ill, lat);
    while (m_row > r) applyStimulus(1, 1'b0, ill, lat);
    while (m_col < c) applyStimulus(3, 1'b0, ill, lat);
    while (m_col > c) applyStimulus(4, 1'b0, ill, lat);
  endtask

  task automatic move5(input int d);
    dir5 = 3'(d);
    @(posedge clk);
    #1;
    dir5 = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic place5(input int r, input int c);
    while (c5r < r) begin move5(2); c5r++; end
    while (c5r > r) begin move5(1); c5r--; end
    while (c5c < c) begin move5(3); c5c++; end
    while (c5c > c) begin move5(4); c5c--; end
    checkOutput("n5_cursor", {cur_row5, cur_col5}, {RW5'(r), RW5'(c)});
    confirm5 = 1'b1;
    @(posedge clk);
    #1;
    confirm5 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  initial begin
    int ill, lat;
    int order[9];

    tbl[0]  = '{0, 1'b1, 0, 0, 2, 0, 0};
    tbl[1]  = '{2, 1'b0, 1, 0, 2, 0, 0};
    tbl[2]  = '{0, 1'b1, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 1'b0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1'b1, 0, 0, 1, 0, 1};
    tbl[5]  = '{3, 1'b0, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 1'b1, 0, 1, 2, 0, 0};
    tbl[7]  = '{2, 1'b0, 1, 1, 2, 0, 0};
    tbl[8]  = '{0, 1'b1, 1, 1, 1, 0, 0};
    tbl[9]  = '{1, 1'b0, 0, 1, 1, 0, 0};
    tbl[10] = '{3, 1'b0, 0, 2, 1, 0, 0};
    tbl[11] = '{0, 1'b1, 0, 2, 1, 1, 0};
    tbl[12] = '{4, 1'b0, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 1'b1, 0, 1, 1, 1, 0};
    tbl[14] = '{2, 1'b1, 1, 1, 1, 1, 0};

    doReset();
    checkOutput("rst_row", cur_row, 0);
    checkOutput("rst_col", cur_col, 0);
    checkOutput("rst_board", board, 0);
    checkOutput("rst_turn", turn, 1);
    checkOutput("rst_winner", winner, 0);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_illegal", illegal, 0);

    for (int i = 0; i < 3; i++) applyStimulus(3, 1'b0, ill, lat);
    checkOutput("right_x3_col", cur_col, WRAP ? 0 : 2);

    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].d, tbl[i].c, ill, lat);
      checkOutput("tbl_row", cur_row, tbl[i].er);
      checkOutput("tbl_col", cur_col, tbl[i].ec);
      checkOutput("tbl_turn", turn, tbl[i].et);
      checkOutput("tbl_winner", winner, tbl[i].ew);
      checkOutput("tbl_game_over", game_over, tbl[i].ew != 0);
      checkOutput("tbl_illegal", ill, tbl[i].ei);
      if (i == 11) checkOutput("win_latency", lat <= 16, 1);
    end

    doReset();
    order = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int i = 0; i < 9; i++) begin
      if (i == 8) checkOutput("draw_pending", winner, 0);
      gotoCell(order[i] / N, order[i] % N);
      applyStimulus(0, 1'b1, ill, lat);
    end
    checkOutput("draw_winner", winner, 3);
    checkOutput("draw_game_over", game_over, 1);

    doReset();
    confirm = 1'b1;
    @(posedge clk);
    #1;
    confirm = 1'b0;
    checkOutput("abort_busy", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("abort_written", board, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_board", board, 0);
    checkOutput("abort_turn", turn, 1);
    checkOutput("abort_busy_low", busy, 0);
    resetn = 1'b1;

    resetn = 1'b0;
    dir = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    dir = '0;
    checkOutput("held_dir_edge", cur_col, 1);
    @(posedge clk);
    #1;
    checkOutput("held_dir_once", cur_col, 1);

    for (int g = 0; g < 6; g++) begin
      doReset();
      for (int op = 0; op < 60; op++) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind < 4) applyStimulus($urandom_range(0, 7), 1'b0, ill, lat);
        else if (kind < 8) applyStimulus(0, 1'b1, ill, lat);
        else applyStimulus($urandom_range(1, 4), 1'b1, ill, lat);
      end
    end

    doReset();
    c5r = 0;
    c5c = 0;
    place5(0, 0); place5(0, 4);
    place5(0, 1); place5(1, 3);
    place5(0, 2); place5(2, 2);
    place5(1, 0);
    checkOutput("n5_pending", winner5, 0);
    place5(3, 1);
    checkOutput("n5_cell", board5[2*(3*N5+1) +: 2], 2);
    checkOutput("n5_winner", winner5, 2);
    checkOutput("n5_game_over", game_over5, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grid_game_ctrl.md
GRID_GAME_CTRL -- requirements
Module: grid_game_ctrl

Interface
REQ-001 Parameter N, default 3, board side length; legal range 3..8.
REQ-002 Parameter K, default 3, in-a-row length needed to win; legal range 3..N.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 dir  input  3  cursor command: 0 Idle, 1 Up, 2 Down, 3 Right, 4 Left; 5..7 treated as Idle.
REQ-006 confirm  input  1  level request to place current player's mark at the cursor.
REQ-007 cur_row, cur_col  output  $clog2(N) each  cursor position; row 0 is the top, col 0 is the left.
REQ-008 board  output  2*N*N  cell i = row*N+col at bits [2i+1:2i]; 0 empty, 1 player one, 2 player two.
REQ-009 turn  output  2  player to move next, 1 or 2.
REQ-010 busy  output  1  high while a placement is being written or checked.
REQ-011 illegal  output  1  one-cycle pulse when a confirm is rejected.
REQ-012 winner  output  2  0 undetermined, 1 player one, 2 player two, 3 draw.
REQ-013 game_over  output  1  high once winner is non-zero; held until reset.

Function
REQ-014 Cursor moves one cell per Idle-to-non-Idle transition of dir (edge detect on registered dir); a held direction moves it once.
REQ-015 At an edge, a move off the board saturates (no change) unless GRID_CURSOR_WRAP_EN is defined.
REQ-016 Confirm is rising-edge detected; only a rising edge in state IDLE is a placement request.
REQ-017 Request on an empty cell: IDLE->PLACE, the cell is written with turn on the following edge, and busy rises in the cycle after the request edge.
REQ-018 Request on an occupied cell: illegal pulses for the next cycle, and board, turn and state stay unchanged.
REQ-019 Rising edge of confirm while busy or game_over: ignored, with no illegal pulse.
REQ-020 When dir and confirm edges coincide, the placement uses the pre-move cursor, and the move still takes effect.
REQ-021 FSM states: IDLE, PLACE, CHECK, SWITCH, DONE; PLACE->CHECK after one cycle.
REQ-022 CHECK walks, one cell per cycle, along 4 axes (horizontal, vertical, diagonal, anti-diagonal) in both senses from the placed cell.
REQ-023 Each sense of the walk stops at the board edge, at a non-matching cell, or after K-1 steps; run = 1 + both senses.
REQ-024 In CHECK, any axis run >= K sets winner=turn and moves to DONE.
REQ-025 CHECK ends no later than 8*(K-1) cycles after entry.
REQ-026 If no win and the placed-mark counter equals N*N, winner=3 and the FSM moves to DONE.
REQ-027 Otherwise SWITCH toggles turn (1<->2), clears busy and returns to IDLE in one cycle.
REQ-028 The placed-mark counter is $clog2(N*N+1) bits wide and increments in PLACE.
REQ-029 DONE is absorbing: game_over=1, busy=0, board frozen; cursor movement stays enabled.

Reset
REQ-030 While resetn=0 at a clock edge: board all 0, cursor (0,0), turn=1, winner=0, game_over=0, busy=0, illegal=0, counter 0, state IDLE.
REQ-031 Reset asserted during PLACE or CHECK aborts the operation; no partial write survives.
REQ-032 On reset, the edge-detect registers for dir and confirm are cleared, so a level held through reset counts as an edge on release.

Configuration
REQ-033 Macro GRID_CURSOR_WRAP_EN defined: a move off any edge wraps to the opposite edge on the same row or column, e.g. Left at col 0 goes to col N-1.
REQ-034 GRID_CURSOR_WRAP_EN undefined: moves off an edge saturate; ports and all other behaviour are identical.

Verification (N=3, K=3 unless stated)
REQ-035 Reset, then Right, Right, Right pulses -> cur_col=2 (saturates); with macro defined -> cur_col=0.
REQ-036 P1 places at 0,1,2 and P2 places at 3,4 -> winner=1, game_over=1 within 16 cycles of the last accepted confirm; further confirms ignored.
REQ-037 Confirm on an already-filled cell -> illegal high for exactly 1 cycle; turn unchanged.
REQ-038 Fill order 0,1,2,4,3,5,7,6,8 (alternating players, no line) -> winner=3 after the 9th placement.
REQ-039 N=5, K=4: P2 marks anti-diagonal cells (0,4),(1,3),(2,2),(3,1) -> winner=2.
REQ-040 Assert resetn=0 during CHECK -> next cycle board=0, turn=1, busy=0.
